lfsr_serial_collector: RTL and testbench
========================================

Name: lfsr_serial_collector

Overview:
Downstream neighbour of the LFSR generator. It consumes the generator's serial bit stream (one bit per Valid-qualified cycle, LSB first) and reassembles Word_bits-bit parallel words. Each completed word is buffered in a 2-entry output queue with a valid/ready handshake, together with an even-parity bit. Overrun and word-count status support bring-up and verification.

Parameters:
Word_bits, 4, bits per reassembled word; must be >= 2 and equal the upstream Shift_bits.

Ports:
CLK  input  1  single clock, rising-edge.
RST  input  1  asynchronous, active-high reset.
Ser_In  input  1  serial data bit, LSB of word first.
Ser_Valid  input  1  Ser_In is valid this cycle.
Clear  input  1  synchronous flush of all state, equivalent to reset.
Par_Out  output  Word_bits  head-of-queue word.
Par_Parity  output  1  XOR of all Par_Out bits (even parity).
Par_Valid  output  1  queue not empty.
Par_Ready  input  1  consumer accepts the head word this cycle.
Overrun  output  1  sticky: a completed word was dropped.
Word_Count  output  8  number of words accepted into the queue, modulo 256.

Behaviour:
- Reset: RST high asynchronously clears all state. This includes the shift register, bit counter, both queue entries and their parity bits, the queue pointers and occupancy, Overrun and Word_Count.
- Output values under reset: Par_Out=0, Par_Parity=0, Par_Valid=0, Overrun=0, Word_Count=0.
- Reset mid-word or mid-handshake discards everything; no partial word survives.
- Assembly:
  - Shift register shreg is Word_bits-1 bits. Bit counter bit_cnt runs 0..Word_bits-1.
  - On Ser_Valid with bit_cnt < Word_bits-1: shreg shifts right with Ser_In entering the MSB, and bit_cnt increments.
  - On Ser_Valid with bit_cnt == Word_bits-1: the completed word is {Ser_In, shreg}. It is pushed to the queue, bit_cnt wraps to 0, and shreg clears.
  - The first received bit ends up as word bit 0.
  - Ser_Valid low holds shreg and bit_cnt; gaps of any length are allowed.
- Latency: Par_Valid rises in the cycle after the edge that samples the final bit, provided the queue was empty.
- Queue states and transitions (occupancy EMPTY / ONE / TWO):
  - pop = Par_Valid && Par_Ready. push = word completion.
  - EMPTY: push -> ONE.
  - ONE: push && !pop -> TWO; pop && !push -> EMPTY; push && pop -> ONE, with the new word becoming head.
  - TWO: pop -> ONE, with a push in the same cycle -> TWO; push && !pop -> word dropped, Overrun set, state stays TWO.
  - A pop and a push in the same cycle while in TWO is never an overrun.
- Word_Count increments on every accepted push, wrapping 255 -> 0. Dropped words do not count.
- Parity: computed at push time and stored with each entry. Par_Parity always corresponds to the current Par_Out.
- Stability: Par_Out and Par_Parity are stable while Par_Valid && !Par_Ready. When the queue is EMPTY, Par_Out holds the last popped value; it is don't-care to the consumer.
- Clear:
  - Clear high on a clock edge empties the queue, zeroes bit_cnt and shreg, clears Overrun and zeroes Word_Count.
  - Clear takes priority over a simultaneous Ser_Valid (that bit is discarded) and over a simultaneous pop/push.
  - Outputs match the reset values in the following cycle.
- Overrun is cleared only by RST or Clear.
- All outputs are registered; there is no combinational path from inputs to outputs.

Test Plan:
- Basic word: Word_bits=4, Par_Ready=1, Ser_Valid=1 for 4 cycles with bits 1,1,0,1 -> one cycle later Par_Valid=1, Par_Out=4'hB, Par_Parity=1, Word_Count=1; Par_Valid drops the next cycle.
- Gapped input: the same bits with Ser_Valid low for 3 cycles between each bit -> identical result, Par_Valid asserted exactly once.
- Back-pressure and overrun:
  - Par_Ready=0; send words 4'h3, 4'h5, 4'h9 -> Par_Out=4'h3 held, occupancy TWO, Overrun=1 after the third word, Word_Count=2.
  - Then Par_Ready=1 -> pops 4'h3 then 4'h5; 4'h9 is never seen; Overrun stays 1.
- Simultaneous push/pop at full: queue holding 4'h3, 4'h5 with Par_Ready=1 in the cycle the word 4'hA completes -> Overrun=0, following outputs 4'h5 then 4'hA, Word_Count=3.
- Reset mid-word: 2 bits sent, RST pulsed asynchronously between edges -> all outputs 0 immediately; the next 4 bits 0,1,1,1 produce Par_Out=4'hE, Par_Parity=1.
- Clear priority: Clear=1 together with Ser_Valid on the 4th bit, queue holding 1 word -> next cycle Par_Valid=0, Word_Count=0, Overrun=0, no word emitted; Word_Count wrap from 255 -> 0 checked by sending 256 words with Par_Ready=1.

Source files
------------

// File: rtl/lfsr_serial_collector.sv
// Reassembles the LFSR generator's LSB-first serial stream into parallel words and
// buffers them, each with an even-parity bit, in a 2-entry valid/ready output queue.
module lfsr_serial_collector #(
  parameter int Word_bits = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 Ser_In,
  input  logic                 Ser_Valid,
  input  logic                 Clear,
  output logic [Word_bits-1:0] Par_Out,
  output logic                 Par_Parity,
  output logic                 Par_Valid,
  input  logic                 Par_Ready,
  output logic                 Overrun,
  output logic [7:0]           Word_Count
);

  // Queue occupancy
  // state   | meaning
  // Q_EMPTY | no word buffered; Par_Out keeps the last popped word
  // Q_ONE   | head word valid on Par_Out
  // Q_TWO   | head on Par_Out, second word waiting in the tail slot
  typedef enum logic [1:0] {
    Q_EMPTY = 2'd0,
    Q_ONE   = 2'd1,
    Q_TWO   = 2'd2
  } q_state_t;

  localparam int CW = $clog2(Word_bits);
  localparam logic [CW-1:0] LAST_BIT = CW'(Word_bits - 1);

  logic [Word_bits-2:0] shreg;
  logic [CW-1:0]        bit_cnt;
  logic [Word_bits-1:0] tail_word;
  logic                 tail_par;
  q_state_t             q_state;

  logic [Word_bits-1:0] new_word;
  logic                 new_par;
  logic                 word_done;
  logic                 pop;

  always_comb begin
    new_word  = {Ser_In, shreg};
    new_par   = ^new_word;
    word_done = Ser_Valid && (bit_cnt == LAST_BIT);
    pop       = Par_Valid && Par_Ready;
  end

  // Bit assembly: incoming bits enter at the MSB so the first bit lands in bit 0.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (Clear) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (Ser_Valid) begin
      if (word_done) begin
        shreg   <= '0;
        bit_cnt <= '0;
      end else begin
        shreg   <= new_word[Word_bits-1:1];
        bit_cnt <= bit_cnt + CW'(1);
      end
    end
  end

  // Output queue; the head entry lives directly in the output registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      q_state    <= Q_EMPTY;
      Par_Out    <= '0;
      Par_Parity <= 1'b0;
      Par_Valid  <= 1'b0;
      tail_word  <= '0;
      tail_par   <= 1'b0;
      Overrun    <= 1'b0;
      Word_Count <= '0;
    end else if (Clear) begin
      q_state    <= Q_EMPTY;
      Par_Out    <= '0;
      Par_Parity <= 1'b0;
      Par_Valid  <= 1'b0;
      tail_word  <= '0;
      tail_par   <= 1'b0;
      Overrun    <= 1'b0;
      Word_Count <= '0;
    end else begin
      case (q_state)
        Q_EMPTY: begin
          if (word_done) begin
            Par_Out    <= new_word;
            Par_Parity <= new_par;
            Par_Valid  <= 1'b1;
            Word_Count <= Word_Count + 8'd1;
            q_state    <= Q_ONE;
          end
        end
        Q_ONE: begin
          case ({word_done, pop})
            2'b10: begin
              tail_word  <= new_word;
              tail_par   <= new_par;
              Word_Count <= Word_Count + 8'd1;
              q_state    <= Q_TWO;
            end
            2'b01: begin
              Par_Valid <= 1'b0;
              q_state   <= Q_EMPTY;
            end
            2'b11: begin
              Par_Out    <= new_word;
              Par_Parity <= new_par;
              Word_Count <= Word_Count + 8'd1;
            end
            default: ;
          endcase
        end
        Q_TWO: begin
          if (pop) begin
            Par_Out    <= tail_word;
            Par_Parity <= tail_par;
            if (word_done) begin
              // a pop frees the slot in the same cycle, so this is never an overrun
              tail_word  <= new_word;
              tail_par   <= new_par;
              Word_Count <= Word_Count + 8'd1;
            end else begin
              q_state <= Q_ONE;
            end
          end else if (word_done) begin
            Overrun <= 1'b1;
          end
        end
        default: begin
          q_state   <= Q_EMPTY;
          Par_Valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_serial_collector.sv
// Scoreboard bench for lfsr_serial_collector: directed serial words with hand-computed
// expected parallel words queued at stimulus time and checked by a separate pop monitor.
module tb_lfsr_serial_collector;

  localparam int W = 4;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         Ser_In = 1'b0;
  logic         Ser_Valid = 1'b0;
  logic         Clear = 1'b0;
  logic         Par_Ready = 1'b0;
  logic [W-1:0] Par_Out;
  logic         Par_Parity;
  logic         Par_Valid;
  logic         Overrun;
  logic [7:0]   Word_Count;

  int n_checks = 0;
  int n_fail = 0;
  int pop_count = 0;
  int p0;
  logic [W:0]   exp_q[$];
  logic [W:0]   mon_e;
  logic [W-1:0] w;

  lfsr_serial_collector #(.Word_bits(W)) dut (
    .CLK(CLK), .RST(RST), .Ser_In(Ser_In), .Ser_Valid(Ser_Valid), .Clear(Clear),
    .Par_Out(Par_Out), .Par_Parity(Par_Parity), .Par_Valid(Par_Valid),
    .Par_Ready(Par_Ready), .Overrun(Overrun), .Word_Count(Word_Count)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // A pop happens on the next rising edge whenever Valid && Ready holds at the falling edge.
  always @(negedge CLK) begin
    if (!RST && !Clear && Par_Valid && Par_Ready) begin
      pop_count++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected: got word %0h expected none", Par_Out);
      end else begin
        mon_e = exp_q.pop_front();
        check("sb_word", {28'd0, Par_Out}, {28'd0, mon_e[W-1:0]});
        check("sb_parity", {31'd0, Par_Parity}, {31'd0, mon_e[W]});
      end
    end
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic send_bit(input logic b);
    Ser_In    = b;
    Ser_Valid = 1'b1;
    tick();
    Ser_Valid = 1'b0;
    Ser_In    = 1'b0;
  endtask

  task automatic send_word(input logic [W-1:0] wd, input int gap);
    for (int i = 0; i < W; i++) begin
      send_bit(wd[i]);
      if (i < W - 1) repeat (gap) tick();
    end
  endtask

  task automatic do_clear;
    Clear = 1'b1;
    tick();
    Clear = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #12;
    check("rst_out", {28'd0, Par_Out}, 32'd0);
    check("rst_parity", {31'd0, Par_Parity}, 32'd0);
    check("rst_valid", {31'd0, Par_Valid}, 32'd0);
    check("rst_overrun", {31'd0, Overrun}, 32'd0);
    check("rst_count", {24'd0, Word_Count}, 32'd0);
    RST = 1'b0;
    tick();

    // Basic word 1,1,0,1 -> 4'hB, parity 1
    Par_Ready = 1'b1;
    exp_q.push_back({1'b1, 4'hB});
    send_word(4'hB, 0);
    check("basic_valid", {31'd0, Par_Valid}, 32'd1);
    check("basic_out", {28'd0, Par_Out}, 32'hB);
    check("basic_parity", {31'd0, Par_Parity}, 32'd1);
    check("basic_count", {24'd0, Word_Count}, 32'd1);
    tick();
    check("basic_valid_drop", {31'd0, Par_Valid}, 32'd0);

    // Gapped input
    p0 = pop_count;
    exp_q.push_back({1'b1, 4'hB});
    send_word(4'hB, 3);
    check("gap_count", {24'd0, Word_Count}, 32'd2);
    repeat (3) tick();
    check("gap_pops", pop_count - p0, 32'd1);

    // Back-pressure and overrun: 3 and 5 kept, 9 dropped
    do_clear();
    check("clr_count", {24'd0, Word_Count}, 32'd0);
    Par_Ready = 1'b0;
    exp_q.push_back({1'b0, 4'h3});
    exp_q.push_back({1'b0, 4'h5});
    send_word(4'h3, 0);
    send_word(4'h5, 0);
    send_word(4'h9, 0);
    check("bp_head", {28'd0, Par_Out}, 32'h3);
    check("bp_valid", {31'd0, Par_Valid}, 32'd1);
    check("bp_overrun", {31'd0, Overrun}, 32'd1);
    check("bp_count", {24'd0, Word_Count}, 32'd2);
    Par_Ready = 1'b1;
    repeat (3) tick();
    check("bp_empty", {31'd0, Par_Valid}, 32'd0);
    check("bp_overrun_sticky", {31'd0, Overrun}, 32'd1);
    check("bp_sb_drained", exp_q.size(), 32'd0);

    // Simultaneous push and pop while full
    do_clear();
    check("clr_overrun", {31'd0, Overrun}, 32'd0);
    Par_Ready = 1'b0;
    exp_q.push_back({1'b0, 4'h3});
    exp_q.push_back({1'b0, 4'h5});
    exp_q.push_back({1'b0, 4'hA});
    send_word(4'h3, 0);
    send_word(4'h5, 0);
    w = 4'hA;
    for (int i = 0; i < W - 1; i++) send_bit(w[i]);
    Par_Ready = 1'b1;
    send_bit(w[W-1]);
    check("full_pp_overrun", {31'd0, Overrun}, 32'd0);
    check("full_pp_head", {28'd0, Par_Out}, 32'h5);
    check("full_pp_count", {24'd0, Word_Count}, 32'd3);
    repeat (3) tick();
    check("full_pp_empty", {31'd0, Par_Valid}, 32'd0);
    check("full_pp_sb_drained", exp_q.size(), 32'd0);

    // Asynchronous reset mid-word with a word pending
    Par_Ready = 1'b0;
    exp_q.push_back({1'b0, 4'h6});
    send_word(4'h6, 0);
    send_bit(1'b1);
    send_bit(1'b0);
    #2 RST = 1'b1;
    #1;
    check("arst_out", {28'd0, Par_Out}, 32'd0);
    check("arst_valid", {31'd0, Par_Valid}, 32'd0);
    check("arst_count", {24'd0, Word_Count}, 32'd0);
    check("arst_overrun", {31'd0, Overrun}, 32'd0);
    exp_q.delete();
    #2 RST = 1'b0;
    tick();
    Par_Ready = 1'b1;
    exp_q.push_back({1'b1, 4'hE});
    send_word(4'hE, 0);
    check("arst_word", {28'd0, Par_Out}, 32'hE);
    check("arst_parity", {31'd0, Par_Parity}, 32'd1);
    check("arst_word_count", {24'd0, Word_Count}, 32'd1);
    tick();

    // Clear beats the final bit of a word and the pending head word
    Par_Ready = 1'b0;
    exp_q.push_back({1'b1, 4'h1});
    send_word(4'h1, 0);
    w = 4'h7;
    for (int i = 0; i < W - 1; i++) send_bit(w[i]);
    Clear     = 1'b1;
    Ser_In    = w[W-1];
    Ser_Valid = 1'b1;
    tick();
    Clear     = 1'b0;
    Ser_Valid = 1'b0;
    exp_q.delete();
    check("clrp_valid", {31'd0, Par_Valid}, 32'd0);
    check("clrp_count", {24'd0, Word_Count}, 32'd0);
    check("clrp_overrun", {31'd0, Overrun}, 32'd0);
    check("clrp_out", {28'd0, Par_Out}, 32'd0);
    p0 = pop_count;
    Par_Ready = 1'b1;
    repeat (4) tick();
    check("clrp_no_word", pop_count - p0, 32'd0);
    exp_q.push_back({1'b1, 4'h7});
    send_word(4'h7, 0);
    tick();
    check("clrp_realign_count", {24'd0, Word_Count}, 32'd1);

    // Word_Count wrap after 256 accepted words
    do_clear();
    Par_Ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      w = i[W-1:0];
      exp_q.push_back({^w, w});
      send_word(w, 0);
      if (i == 254) check("wrap_count_255", {24'd0, Word_Count}, 32'd255);
    end
    check("wrap_count_0", {24'd0, Word_Count}, 32'd0);
    repeat (2) tick();
    check("wrap_sb_drained", exp_q.size(), 32'd0);
    check("wrap_overrun", {31'd0, Overrun}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
